// File: rtl/mem_arb_if.sv
// mem_arb_if: bundle of every bus signal around mem_arb.
//   cpu_*  : CPU request/acknowledge channel (req, we, addr, wdata in; ack, rdata out)
//   host_* : host loader/debug channel, same shape as cpu_*
//   mem_*  : single-port synchronous RAM strobes (ce, we, addr, wdata out; rdata in)
//   owner  : current bus owner, 00 none, 01 CPU, 10 host
// Modports:
//   slave  : the arbiter's view
//   master : the view of the surrounding requesters and RAM
interface mem_arb_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;

  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_ce, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: two-port arbiter sharing one synchronous RAM between the CPU core and the
// host loader/debug port. Serialises requests, drives the RAM strobes and returns read
// data with a one-cycle acknowledge per transaction.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_arb_if.slave -- cpu_*, host_*, mem_* and owner signals
//
// Build option:
//   MEM_ARB_RR_EN defined   -> round-robin on simultaneous requests in idle
//   MEM_ARB_RR_EN undefined -> fixed priority, CPU first
//
// Timing: read ack three cycles after req is seen in idle, write ack two cycles after.
// The ack state hands the bus straight to the other port when it is waiting.
module mem_arb #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input logic         clk,
  input logic         rst_n,
  mem_arb_if.slave    bus
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAcc  = 3'd1,
    StRd   = 3'd2,
    StAck  = 3'd3
  } state_e;

  // Raw bits so that the unused encodings stay representable and recover to idle.
  logic [2:0]    state_q;
  state_e        state_d;

  // Port select encoding: 0 = CPU, 1 = host.
  logic          sel_q, sel_d;
  logic          last_q, last_d;

  logic [DW-1:0] cpu_rdata_q, host_rdata_q;

  logic          win_host;
  logic          other_req;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [1:0]    sel_owner;

  assign sel_we    = sel_q ? bus.host_we    : bus.cpu_we;
  assign sel_addr  = sel_q ? bus.host_addr  : bus.cpu_addr;
  assign sel_wdata = sel_q ? bus.host_wdata : bus.cpu_wdata;
  assign sel_owner = sel_q ? 2'b10 : 2'b01;
  assign other_req = sel_q ? bus.cpu_req : bus.host_req;

`ifdef MEM_ARB_RR_EN
  // On a tie the port that was not served last wins.
  assign win_host = bus.host_req & (~bus.cpu_req | ~last_q);
`else
  assign win_host = bus.host_req & ~bus.cpu_req;
`endif

  always_comb begin
    state_d        = StIdle;
    sel_d          = sel_q;
    last_d         = last_q;
    bus.mem_ce     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.cpu_ack    = 1'b0;
    bus.host_ack   = 1'b0;
    bus.owner      = 2'b00;

    case (state_e'(state_q))
      StIdle: begin
        if (bus.cpu_req || bus.host_req) begin
          sel_d   = win_host;
          state_d = StAcc;
        end
      end

      StAcc: begin
        bus.mem_ce    = 1'b1;
        bus.mem_we    = sel_we;
        bus.mem_addr  = sel_addr;
        bus.mem_wdata = sel_wdata;
        bus.owner     = sel_owner;
        state_d       = sel_we ? StAck : StRd;
      end

      StRd: begin
        bus.owner = sel_owner;
        state_d   = StAck;
      end

      StAck: begin
        bus.owner    = sel_owner;
        bus.cpu_ack  = ~sel_q;
        bus.host_ack = sel_q;
        last_d       = sel_q;
        // The just-served port's req is ignored here; only the other port can follow.
        if (other_req) begin
          sel_d   = ~sel_q;
          state_d = StAcc;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  // RAM data is valid during RD; capture it at the end of that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else if (state_q == StRd) begin
      if (sel_q) begin
        host_rdata_q <= bus.mem_rdata;
      end else begin
        cpu_rdata_q  <= bus.mem_rdata;
      end
    end
  end

  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.host_rdata = host_rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: self-checking bench for mem_arb. A behavioural RAM sits on the mem_* side;
// a shadow memory updated at each acknowledge predicts read data, and directed
// cycle-by-cycle sequences plus randomised two-port traffic exercise the arbiter.
module tb_mem_arb;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arb_if #(.AW(AW), .DW(DW)) bus ();

  mem_arb #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input int i);
    if (i == 16) return 16'hA5A5;
    return 16'((i * 40503) ^ 23130);
  endfunction

  // Behavioural synchronous RAM: read data appears the cycle after ce with we=0.
  logic [15:0] ram [256];
  logic [15:0] ram_q = '0;
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_ce) begin
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
        else            ram_q = ram[bus.mem_addr];
      end
    end
  end
  assign bus.mem_rdata = ram_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [7:0] a, input logic [15:0] d);
    if (port == 0) begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end else begin
      bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    end
  endtask

  // Wait for the next negedge and compare the strobe/ack/owner picture of that cycle.
  task automatic expect_cyc(input string tag, input logic ce, input logic we,
                            input logic [1:0] own, input logic cack, input logic hack);
    @(negedge clk);
    check({tag, "_ce"},    32'(bus.mem_ce),   32'(ce));
    check({tag, "_we"},    32'(bus.mem_we),   32'(we));
    check({tag, "_owner"}, 32'(bus.owner),    32'(own));
    check({tag, "_cack"},  32'(bus.cpu_ack),  32'(cack));
    check({tag, "_hack"},  32'(bus.host_ack), 32'(hack));
  endtask

  // One transaction from a port: present it after the next posedge, wait for its ack.
  task automatic txn(input int port, input logic we, input logic [7:0] a,
                     input logic [15:0] d, output int lat, output int at);
    int  t0;
    bit  got;
    @(posedge clk);
    #1;
    drive(port, 1'b1, we, a, d);
    t0  = cyc;
    got = 1'b0;
    lat = -1;
    at  = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((port == 0) ? bus.cpu_ack : bus.host_ack) begin
        got = 1'b1;
        lat = cyc - t0;
        at  = cyc;
      end
    end
    check("txn_ack_seen", 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: shadow memory, expected rdata registers and bus-wide rules.
  logic [15:0] shadow [256];
  logic [15:0] exp_cpu, exp_host;
  logic        prev_cack, prev_hack;
  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    exp_cpu = '0; exp_host = '0; prev_cack = 1'b0; prev_hack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cpu = '0; exp_host = '0; prev_cack = 1'b0; prev_hack = 1'b0;
        check("rst_cpu_ack",    32'(bus.cpu_ack),    32'd0);
        check("rst_host_ack",   32'(bus.host_ack),   32'd0);
        check("rst_cpu_rdata",  32'(bus.cpu_rdata),  32'd0);
        check("rst_host_rdata", 32'(bus.host_rdata), 32'd0);
        check("rst_mem_ce",     32'(bus.mem_ce),     32'd0);
        check("rst_owner",      32'(bus.owner),      32'd0);
      end else begin
        if (bus.cpu_ack) begin
          if (bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_wdata;
          else            exp_cpu = shadow[bus.cpu_addr];
          check("cpu_ack_owner", 32'(bus.owner), 32'd1);
          check("cpu_ack_b2b",   32'(prev_cack), 32'd0);
        end
        if (bus.host_ack) begin
          if (bus.host_we) shadow[bus.host_addr] = bus.host_wdata;
          else             exp_host = shadow[bus.host_addr];
          check("host_ack_owner", 32'(bus.owner), 32'd2);
          check("host_ack_b2b",   32'(prev_hack), 32'd0);
        end
        check("cpu_rdata",  32'(bus.cpu_rdata),  32'(exp_cpu));
        check("host_rdata", 32'(bus.host_rdata), 32'(exp_host));
        if (bus.mem_ce) begin
          if (bus.owner == 2'b01) begin
            check("mem_addr_cpu", 32'(bus.mem_addr), 32'(bus.cpu_addr));
            check("mem_we_cpu",   32'(bus.mem_we),   32'(bus.cpu_we));
            if (bus.cpu_we) check("mem_wdata_cpu", 32'(bus.mem_wdata), 32'(bus.cpu_wdata));
          end else begin
            check("mem_ce_owner", 32'(bus.owner),    32'd2);
            check("mem_addr_host", 32'(bus.mem_addr), 32'(bus.host_addr));
            check("mem_we_host",   32'(bus.mem_we),   32'(bus.host_we));
            if (bus.host_we) check("mem_wdata_host", 32'(bus.mem_wdata), 32'(bus.host_wdata));
          end
        end else begin
          check("idle_mem_bus", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
        end
        prev_cack = bus.cpu_ack;
        prev_hack = bus.host_ack;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int T, l, a, ca, ha;
    int c_at [3];
    int h_at [3];
    logic [15:0] cpu_before;

    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    expect_cyc("post_rst", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    check("post_rst_addr", 32'(bus.mem_addr), 32'd0);

    // CPU read of 0x10 from idle.
    @(posedge clk); #1 drive(0, 1'b1, 1'b0, 8'h10, 16'h0000);
    expect_cyc("rd_c0", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    expect_cyc("rd_c1", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    check("rd_c1_addr", 32'(bus.mem_addr), 32'h10);
    expect_cyc("rd_c2", 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    expect_cyc("rd_c3", 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    check("rd_data", 32'(bus.cpu_rdata), 32'hA5A5);
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    expect_cyc("rd_c4", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    check("rd_hold", 32'(bus.cpu_rdata), 32'hA5A5);

    // Host write 0x20 <- 0x1234, then CPU reads it back.
    @(posedge clk); #1 drive(1, 1'b1, 1'b1, 8'h20, 16'h1234);
    expect_cyc("wr_c0", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    expect_cyc("wr_c1", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    check("wr_c1_addr",  32'(bus.mem_addr),  32'h20);
    check("wr_c1_wdata", 32'(bus.mem_wdata), 32'h1234);
    expect_cyc("wr_c2", 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(0, 1'b1, 1'b0, 8'h20, 16'h0000);
    expect_cyc("rb_c0", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    expect_cyc("rb_c1", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    expect_cyc("rb_c2", 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    expect_cyc("rb_c3", 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    check("rb_data",         32'(bus.cpu_rdata),  32'h1234);
    check("rb_host_rdata",   32'(bus.host_rdata), 32'h0000);
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Both ports request together straight after reset and keep requesting.
    do_reset();
    @(negedge clk);
    T = cyc + 1;
    fork
      begin
        int lc, ac;
        for (int k = 0; k < 3; k++) begin
          txn(0, 1'b0, 8'($urandom_range(255, 0)), 16'h0000, lc, ac);
          c_at[k] = ac;
        end
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
      begin
        int lh, ah;
        for (int k = 0; k < 3; k++) begin
          txn(1, 1'b0, 8'($urandom_range(255, 0)), 16'h0000, lh, ah);
          h_at[k] = ah;
        end
        @(posedge clk); #1 drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
    join
    for (int k = 0; k < 3; k++) begin
      check("alt_cpu_ack_cycle",  32'(c_at[k] - T), 32'(3 + 6 * k));
      check("alt_host_ack_cycle", 32'(h_at[k] - T), 32'(6 + 6 * k));
    end

    // CPU served last, then a tie in idle: the build option decides the winner.
    txn(0, 1'b0, 8'h10, 16'h0000, l, a);
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    T = cyc + 1;
    fork
      begin
        int lc;
        txn(0, 1'b0, 8'h30, 16'h0000, lc, ca);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
      begin
        int lh;
        txn(1, 1'b0, 8'h31, 16'h0000, lh, ha);
        @(posedge clk); #1 drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
    join
`ifdef MEM_ARB_RR_EN
    check("tie_cpu_ack_cycle",  32'(ca - T), 32'd6);
    check("tie_host_ack_cycle", 32'(ha - T), 32'd3);
`else
    check("tie_cpu_ack_cycle",  32'(ca - T), 32'd3);
    check("tie_host_ack_cycle", 32'(ha - T), 32'd6);
`endif

    // CPU holds req across four reads with the host idle.
    for (int k = 0; k < 4; k++) begin
      txn(0, 1'b0, 8'($urandom_range(255, 0)), 16'h0000, l, a);
      check("held_read_latency", 32'(l), 32'd3);
    end
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Reset asserted during RD of a CPU read.
    cpu_before = bus.cpu_rdata;
    @(posedge clk); #1 drive(0, 1'b1, 1'b0, 8'h10, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_in_rd_owner", 32'(bus.owner), 32'd1);
    #2 rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    check("mid_rst_owner",     32'(bus.owner),     32'd0);
    check("mid_rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
    check("mid_rst_mem_ce",    32'(bus.mem_ce),    32'd0);
    check("mid_rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    check("mid_rst_rdata_was_nonzero", 32'(cpu_before != 16'h0000), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) expect_cyc("after_rst", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Unused state encoding must fall back to idle.
    @(negedge clk);
    #1 force dut.state_q = 3'd5;
    #1;
    check("bad_state_mem_ce",   32'(bus.mem_ce),   32'd0);
    check("bad_state_cpu_ack",  32'(bus.cpu_ack),  32'd0);
    check("bad_state_host_ack", 32'(bus.host_ack), 32'd0);
    @(posedge clk); #1 release dut.state_q;
    @(posedge clk); #1;
    check("bad_state_recovers", 32'(dut.state_q), 32'd0);
    check("bad_state_mem_ce_after", 32'(bus.mem_ce), 32'd0);

    // Randomised traffic from both ports on a small address window.
    fork
      for (int p = 0; p < 2; p++) begin
        automatic int port = p;
        fork
          begin
            for (int k = 0; k < 30; k++) begin
              int   lr, ar, g;
              logic we;
              we = 1'($urandom);
              txn(port, we, 8'($urandom_range(7, 0)), 16'($urandom), lr, ar);
              check("rnd_lat_min", 32'(lr >= (we ? 2 : 3)), 32'd1);
              check("rnd_lat_max", 32'(lr <= 8), 32'd1);
              g = $urandom_range(3, 0);
              if (g > 0) begin
                @(posedge clk); #1 drive(port, 1'b0, 1'b0, 8'h00, 16'h0000);
                repeat (g - 1) @(posedge clk);
              end
            end
            @(posedge clk); #1 drive(port, 1'b0, 1'b0, 8'h00, 16'h0000);
          end
        join_none
      end
    join
    wait fork;

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
